// File: rtl/vm_pkg.sv
// Coin codes shared by the coin acceptor and the vending FSM.
package vm_pkg;

  typedef logic [1:0] coin_t;

  localparam coin_t COIN_NONE = 2'b00;
  localparam coin_t COIN_5    = 2'b01;
  localparam coin_t COIN_10   = 2'b10;

endpackage

// File: rtl/coin_debounce.sv
// One coin-sensor channel: 2-flop synchronizer followed by a counter-based
// debouncer. `rise` is combinational and is high on the very edge where the
// debounced level goes 0->1, so the caller can enqueue on that same edge.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          s;
  logic          d;
  logic [CW-1:0] cnt;
  logic          settle;

  // The synchronized level has differed from `d` long enough to be accepted.
  assign settle = (s != d) && (cnt == CNT_LAST);
  assign rise   = settle && s;
  assign level  = d;

  // Two-flop synchronizer for the asynchronous sensor level.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
    end
  end

  // Count consecutive disagreeing cycles; toggle `d` once the count is reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d   <= 1'b0;
      cnt <= '0;
    end else if (s == d) begin
      cnt <= '0;
    end else if (settle) begin
      d   <= ~d;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: debounces the nickel and dime sensors, buffers
// accepted coins in a small FIFO with two write ports, and releases one code
// per cycle to the vending FSM whenever it is not vending.
module coin_acceptor
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin5_raw,
  input  logic       coin10_raw,
  input  logic       busy,
  output logic [1:0] coin,
  output logic       full,
  output logic       dropped
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic          level5;
  logic          level10;
  logic          rise5;
  logic          rise10;
  logic          unused_levels;

  coin_t         mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          pop;
  logic [CW-1:0] free;
  logic [1:0]    n_ev;
  logic [1:0]    num_wr;
  coin_t         first_code;
  logic          discard;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb5 (
    .clk   (clk),
    .reset (reset),
    .raw   (coin5_raw),
    .level (level5),
    .rise  (rise5)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb10 (
    .clk   (clk),
    .reset (reset),
    .raw   (coin10_raw),
    .level (level10),
    .rise  (rise10)
  );

  // Debounced levels are only interesting for debug; coins come from `rise`.
  assign unused_levels = level5 ^ level10;

  assign full = (count == CW'(FIFO_DEPTH));

  // Output code, pop, free space and how many of this edge's events fit.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    coin       = COIN_NONE;
    pop        = 1'b0;
    free       = '0;
    n_ev       = 2'd0;
    num_wr     = 2'd0;
    first_code = COIN_NONE;
    discard    = 1'b0;

    if ((count != '0) && !busy) begin
      coin = mem[rd_ptr];
    end
    pop = (coin != COIN_NONE);

    // A same-cycle pop frees a slot for this edge's writes.
    free = CW'(FIFO_DEPTH) - count + CW'(pop);
    n_ev = {1'b0, rise5} + {1'b0, rise10};

    if (CW'(n_ev) <= free) begin
      num_wr = n_ev;
    end else begin
      num_wr = free[1:0];
    end

    // The nickel always takes the first slot when both channels fire.
    first_code = rise5 ? COIN_5 : COIN_10;
    discard    = (n_ev != num_wr);
  end

  // FIFO pointers, occupancy and the registered drop pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      dropped <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + PW'(num_wr);
      rd_ptr  <= rd_ptr + PW'(pop);
      count   <= count + CW'(num_wr) - CW'(pop);
      dropped <= discard;
    end
  end

  // Two-port FIFO storage; second write lands one slot past the first.
  // NOTE: storage is deliberately not reset; `count` alone decides which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (num_wr != 2'd0) begin
      mem[wr_ptr] <= first_code;
    end
    if (num_wr == 2'd2) begin
      mem[wr_ptr + PW'(1)] <= COIN_10;
    end
  end

endmodule
